// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state codes, opcode/funct constants and control encodings for mips_multicycle_ctrl
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [2:0] SRCB_B       = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_SEXT    = 3'b010;
    localparam logic [2:0] SRCB_SEXT_SH = 3'b011;
    localparam logic [2:0] SRCB_ZEXT    = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // Execution state chosen out of DECODE; S_FETCH doubles as the "unsupported" result.
    function automatic logic [3:0] dispatch(input logic [5:0] opcode, input logic [5:0] funct);
        logic [3:0] nxt;
        nxt = S_FETCH;
        case (opcode)
            OP_LW, OP_SW:                     nxt = S_MEM_ADDR;
            OP_RTYPE: begin
                case (funct)
                    FN_JR:                                  nxt = S_JR;
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  nxt = S_R_EXEC;
                    default:                                nxt = S_FETCH;
                endcase
            end
            OP_BEQ, OP_BNE:                   nxt = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = S_I_EXEC;
            OP_J:                             nxt = S_JUMP;
            OP_JAL:                           nxt = S_JAL;
            default:                          nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational state/opcode to control-vector mapping
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_SEXT_SH;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = (dispatch(opcode, funct) == S_FETCH);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (opcode == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                case (opcode)
                    OP_ANDI: begin ctrl.alu_src_b = SRCB_ZEXT; ctrl.alu_op = ALU_AND; end
                    OP_ORI:  begin ctrl.alu_src_b = SRCB_ZEXT; ctrl.alu_op = ALU_OR;  end
                    OP_SLTI: begin ctrl.alu_src_b = SRCB_SEXT; ctrl.alu_op = ALU_SLT; end
                    default: begin ctrl.alu_src_b = SRCB_SEXT; ctrl.alu_op = ALU_ADD; end
                endcase
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            // PC already holds PC+4 here, so linking and jumping share one edge.
            S_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
            end
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_REG;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM; MIPS_CTRL_PERF_EN adds cycle/retire counters
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
`ifdef MIPS_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_retired
`endif
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl_dec;
    ctrl_t      ctrl_o;

    // The branch decision itself is resolved in the datapath via pc_write_cond/branch_ne.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = dispatch(opcode, funct);
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state  (state_q),
        .opcode (opcode),
        .funct  (funct),
        .ctrl   (ctrl_dec)
    );

    // Only the FETCH-stage loads wait on memory; reset silences every control line at once.
    always_comb begin
        ctrl_o = ctrl_dec;
        if (state_q == S_FETCH && !mem_ready) begin
            ctrl_o.pc_write = 1'b0;
            ctrl_o.ir_write = 1'b0;
        end
        if (!rstb) ctrl_o = '0;
    end

    assign pc_write      = ctrl_o.pc_write;
    assign pc_write_cond = ctrl_o.pc_write_cond;
    assign branch_ne     = ctrl_o.branch_ne;
    assign i_or_d        = ctrl_o.i_or_d;
    assign mem_read      = ctrl_o.mem_read;
    assign mem_write     = ctrl_o.mem_write;
    assign ir_write      = ctrl_o.ir_write;
    assign reg_write     = ctrl_o.reg_write;
    assign reg_dst       = ctrl_o.reg_dst;
    assign mem_to_reg    = ctrl_o.mem_to_reg;
    assign alu_src_a     = ctrl_o.alu_src_a;
    assign alu_src_b     = ctrl_o.alu_src_b;
    assign alu_op        = ctrl_o.alu_op;
    assign pc_source     = ctrl_o.pc_source;
    assign illegal_op    = ctrl_o.illegal_op;
    assign state         = state_q;

`ifdef MIPS_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cycle_count   <= 32'd0;
            instr_retired <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (state_d == S_FETCH && state_q != S_FETCH)
                instr_retired <= instr_retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic [3:0] state;
    } obs_t;

    logic       clk = 1'b0;
    logic       rstb;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_write, alu_src_a, illegal_op;
    logic [1:0] reg_dst, mem_to_reg, pc_source;
    logic [2:0] alu_src_b, alu_op;
    logic [3:0] state;
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_count, instr_retired;
`endif

    obs_t o_dut;
    int   checks = 0;
    int   failures = 0;
    int   ill_seen = 0;
    int   wr_seen = 0;
    int   n_ret = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rstb(rstb), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
        .state(state)
`ifdef MIPS_CTRL_PERF_EN
        , .cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
    );

    assign o_dut = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                    ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                    alu_op, pc_source, illegal_op, state};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return fn inside {6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    endfunction

    // Control lines expected in a given step of an instruction, straight from the state table.
    function automatic obs_t model(input int st, input logic [5:0] op, input logic [5:0] fn,
                                   input logic mr);
        obs_t e;
        e = '0;
        e.state = 4'(st);
        case (st)
            0:  begin e.mem_read = 1; e.alu_src_b = 3'd1; e.pc_write = mr; e.ir_write = mr; end
            1:  begin e.alu_src_b = 3'd3; e.illegal_op = !is_legal(op, fn); end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 3'd2; end
            3:  begin e.mem_read = 1; e.i_or_d = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 2'd1; end
            5:  begin e.mem_write = 1; e.i_or_d = 1; end
            6:  begin e.alu_src_a = 1; e.alu_op = 3'd2; end
            7:  begin e.reg_write = 1; e.reg_dst = 2'd1; end
            8:  begin e.alu_src_a = 1; e.alu_op = 3'd1; e.pc_write_cond = 1;
                      e.pc_source = 2'd1; e.branch_ne = (op == 6'h05); end
            9:  begin e.pc_write = 1; e.pc_source = 2'd2; end
            10: begin
                    e.alu_src_a = 1;
                    e.alu_src_b = (op == 6'h0C || op == 6'h0D) ? 3'd4 : 3'd2;
                    e.alu_op = (op == 6'h0A) ? 3'd5 : (op == 6'h0C) ? 3'd3 :
                               (op == 6'h0D) ? 3'd4 : 3'd0;
                end
            11: begin e.reg_write = 1; end
            12: begin e.reg_write = 1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
                      e.pc_write = 1; e.pc_source = 2'd2; end
            13: begin e.pc_write = 1; e.pc_source = 2'd3; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic cyc(input int st, input logic mr, output obs_t got);
        mem_ready = mr;
        alu_zero = 1'($urandom);
        @(negedge clk);
        got = o_dut;
        chk($sformatf("cycle_state%0d_op%02h", st, opcode), 32'(got),
            32'(model(st, opcode, funct, mr)));
        ill_seen += int'(got.illegal_op);
        wr_seen += int'(got.reg_write) + int'(got.mem_write);
        @(posedge clk);
        #1;
    endtask

    // Expands one instruction into its state walk, with nf FETCH and nm memory wait cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int nf,
                             input int nm, output obs_t last);
        obs_t g;
        opcode = op;
        funct = fn;
        repeat (nf) cyc(0, 1'b0, g);
        cyc(0, 1'b1, g);
        cyc(1, 1'($urandom), g);
        last = g;
        if (op == 6'h23) begin
            cyc(2, 1'($urandom), g);
            repeat (nm) cyc(3, 1'b0, g);
            cyc(3, 1'b1, g);
            cyc(4, 1'($urandom), last);
        end else if (op == 6'h2B) begin
            cyc(2, 1'($urandom), g);
            repeat (nm) cyc(5, 1'b0, g);
            cyc(5, 1'b1, last);
        end else if (op == 6'h00 && fn == 6'h08) begin
            cyc(13, 1'($urandom), last);
        end else if (op == 6'h00 && is_legal(op, fn)) begin
            cyc(6, 1'($urandom), g);
            cyc(7, 1'($urandom), last);
        end else if (op == 6'h04 || op == 6'h05) begin
            cyc(8, 1'($urandom), last);
        end else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D}) begin
            cyc(10, 1'($urandom), g);
            cyc(11, 1'($urandom), last);
        end else if (op == 6'h02) begin
            cyc(9, 1'($urandom), last);
        end else if (op == 6'h03) begin
            cyc(12, 1'($urandom), last);
        end
        n_ret++;
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rstb = 1'b0;
        #1;
        chk({tag, "_async_zero"}, 32'(o_dut), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_hold_zero"}, 32'(o_dut), 32'd0);
`ifdef MIPS_CTRL_PERF_EN
        chk({tag, "_cycle_count"}, cycle_count, 32'd0);
        chk({tag, "_instr_retired"}, instr_retired, 32'd0);
`endif
        rstb = 1'b1;
        n_ret = 0;
    endtask

    initial begin
        obs_t last, g;
        int   w0, i0;
        logic [5:0] ops[12];
        logic [5:0] fns[6];
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h00};
        fns = '{6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        rstb = 1'b0;
        mem_ready = 1'b1;
        alu_zero = 1'b0;
        opcode = 6'h23;
        funct = 6'h20;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", 32'(o_dut), 32'd0);
`ifdef MIPS_CTRL_PERF_EN
        chk("reset_cycle_count", cycle_count, 32'd0);
        chk("reset_instr_retired", instr_retired, 32'd0);
`endif
        rstb = 1'b1;

        run_instr(6'h23, 6'h00, 2, 2, last);
        chk("lw_wb_mem_to_reg", 32'(last.mem_to_reg), 32'd1);
        chk("lw_wb_state", 32'(last.state), 32'd4);

        run_instr(6'h04, 6'h00, 0, 0, last);
        chk("beq_branch_ne", 32'(last.branch_ne), 32'd0);
        chk("beq_pc_write_cond", 32'(last.pc_write_cond), 32'd1);
        run_instr(6'h05, 6'h00, 0, 0, last);
        chk("bne_branch_ne", 32'(last.branch_ne), 32'd1);

        run_instr(6'h03, 6'h00, 0, 0, last);
        chk("jal_fields", {last.reg_write, last.reg_dst, last.mem_to_reg, last.pc_write,
                           last.pc_source}, 32'b1_10_10_1_10);

        w0 = wr_seen;
        run_instr(6'h00, 6'h08, 1, 0, last);
        chk("jr_pc_source", 32'(last.pc_source), 32'd3);
        chk("jr_no_writes", 32'(wr_seen - w0), 32'd0);

        w0 = wr_seen;
        i0 = ill_seen;
        run_instr(6'h3F, 6'h00, 0, 0, last);
        chk("illegal_pulse_count", 32'(ill_seen - i0), 32'd1);
        chk("illegal_no_writes", 32'(wr_seen - w0), 32'd0);
        cyc(0, 1'b0, g);
        reset_pulse("mid_fetch");

        opcode = 6'h23;
        funct = 6'h00;
        cyc(0, 1'b1, g);
        cyc(1, 1'b1, g);
        cyc(2, 1'b1, g);
        cyc(3, 1'b0, g);
        mem_ready = 1'b0;
        reset_pulse("mid_mem_read");

        for (int k = 0; k < 150; k++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 11)];
            fn = fns[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), last);
        end

`ifdef MIPS_CTRL_PERF_EN
        chk("final_instr_retired", instr_retired, 32'(n_ret));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control state machine that sequences the shared multicycle MIPS datapath: PC, instruction/data memory port, register file, ALU and the A/B/ALUOut/MDR staging registers. It sits inside mips_core beside REGISTER_FILE. It decodes opcode/funct and drives every mux select and write enable, one state per cycle. It stalls on a memory-ready handshake.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); must not be changed except for bench experiments.

Ports:
clk  in  1  system clock, rising edge
rstb  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag (from the A-B compare)
mem_ready  in  1  memory completes the access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if the branch condition holds
branch_ne  out  1  1 = branch condition is !alu_zero (bne), 0 = alu_zero (beq)
i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_write  out  1  register file write enable
reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  3  000 = B, 001 = 4, 010 = sext(imm), 011 = sext(imm)<<2, 100 = zext(imm)
alu_op  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}, 11 = A
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode or funct
state  out  4  current state, for debug

Behaviour:
- Reset: asynchronous on rstb=0. State goes to FETCH. All registered outputs go to 0 and illegal_op goes to 0.
- Control outputs are Moore, decoded from state. The exceptions are pc_write and ir_write in FETCH, which are gated by mem_ready.
- States and transitions:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=001, alu_op=add, pc_source=00. Stay in FETCH while mem_ready=0. When mem_ready=1, assert ir_write and pc_write and go to DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=011, alu_op=add (precomputes the branch target). Next state by opcode:
    - lw/sw (0x23/0x2B) -> MEM_ADDR
    - R-type (0x00) with funct 0x08 (jr) -> JR
    - other supported R-type funct (add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A) -> R_EXEC
    - beq/bne (0x04/0x05) -> BRANCH
    - addi/slti (0x08/0x0A) and andi/ori (0x0C/0x0D) -> I_EXEC
    - j (0x02) -> JUMP
    - jal (0x03) -> JAL
    - anything else -> FETCH with illegal_op=1
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=010, add. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ(3): mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
  - MEM_WB(4): reg_write=1, reg_dst=00, mem_to_reg=01. Then FETCH.
  - MEM_WRITE(5): mem_write=1, i_or_d=1. Wait for mem_ready, then FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=000, alu_op=010. Then R_WB.
  - R_WB(7): reg_write=1, reg_dst=01, mem_to_reg=00. Then FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=000, sub, pc_write_cond=1, pc_source=01, branch_ne=(opcode==0x05). Then FETCH.
  - JUMP(9): pc_write=1, pc_source=10. Then FETCH.
  - I_EXEC(10): alu_src_a=1. alu_src_b=100 for andi/ori, 010 otherwise. alu_op: add for addi, slt for slti, and for andi, or for ori. Then I_WB.
  - I_WB(11): reg_write=1, reg_dst=00, mem_to_reg=00. Then FETCH.
  - JAL(12): reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4; no delay slot), pc_write=1, pc_source=10. The register write and the PC update happen on the same edge. Then FETCH.
  - JR(13): pc_write=1, pc_source=11. Then FETCH.
  - Codes 14 and 15: go to FETCH with no side effects.
- Latency in cycles, excluding memory stalls:
  - lw 5
  - sw 4
  - R-type 4
  - I-type ALU 4
  - beq/bne, j, jal, jr 3
- Memory handshake:
  - While waiting, mem_read/mem_write and i_or_d are held stable.
  - mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- An illegal opcode writes no register and no memory; PC has already advanced by 4.

Optional Feature:
MIPS_CTRL_PERF_EN
- Defined: adds outputs cycle_count[31:0] and instr_retired[31:0], both reset to 0 by rstb.
  - cycle_count increments every clock.
  - instr_retired increments on each transition into FETCH from any state other than FETCH, including illegal_op returns.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Package mips_ctrl_pkg:
  - state codes
  - opcode and funct constants
  - alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg encodings
- Optional sub-module mips_ctrl_decode: purely combinational mapping from state/opcode to the output vector. The sequential FSM stays in the top module.

Test Plan:
- Hold rstb=0, then release with mem_ready=1 -> all outputs 0 during reset; FETCH asserts ir_write and pc_write on the first edge; state sequence 0,1.
- Feed lw (0x23), with mem_ready=0 for 2 cycles in both FETCH and MEM_READ -> states 0,0,0,1,2,3,3,3,4,0; reg_write only in state 4 with mem_to_reg=01.
- beq with alu_zero=1, then bne with alu_zero=1 -> pc_write_cond=1 in state 8 both times; branch_ne=0 then 1; 3 cycles each.
- jal (0x03) -> JAL state has reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10. On the full core, jal at 0x00400060 leaves r31 = 0x00400064.
- jr (opcode 0, funct 0x08) -> DECODE goes to JR; pc_source=11, pc_write=1; no reg_write in any cycle.
- Opcode 0x3F, then a mid-FETCH rstb pulse -> illegal_op for one cycle, back to FETCH with no writes; async reset forces FETCH and zeros outputs immediately. With MIPS_CTRL_PERF_EN, counters read 0 after reset.
